// File: rtl/ram_pkg.sv
// Shared types, constants and sizing helpers for the ram_sync_ext memory family.
package ram_pkg;

  typedef enum logic [0:0] {IDLE, CLEAR} clr_state_t;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Packages cannot see instance parameters, so users derive NUM_LANES/DEPTH through these.
  function automatic int unsigned calc_num_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned calc_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_sync_ext_if.sv
// Read/write request bus between a memory client (master) and ram_sync_ext (slave).
interface ram_sync_ext_if
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]                 read_addr;
  logic                                  read_en;
  logic [ADDR_WIDTH-1:0]                 write_addr;
  logic                                  write;
  logic [calc_num_lanes(DATA_WIDTH)-1:0] write_be;
  logic [DATA_WIDTH-1:0]                 din;
  logic [DATA_WIDTH-1:0]                 dout;
  logic                                  dout_valid;
  logic                                  busy;

  modport master (
    output read_addr, read_en, write_addr, write, write_be, din,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  read_addr, read_en, write_addr, write, write_be, din,
    output dout, dout_valid, busy
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Delay line carrying {valid, data}; each stage only reloads data when a valid arrives,
// so the last stage holds the most recent result between reads.
module ram_rd_pipe #(
  parameter int unsigned STAGES     = 0,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end else begin : g_stages
    logic [STAGES-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q [STAGES];

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= '0;
        for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        if (valid_i) data_q[0] <= data_i;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/ram_sync_ext.sv
// Synchronous 1R1W RAM with byte enables, pipelined reads, selectable read-during-write
// policy and an optional post-reset clear sequencer.
module ram_sync_ext
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = RDW_READ_FIRST,
  parameter string       INIT_FILE      = "data.txt",
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input logic           clk,
  input logic           rst,
  ram_sync_ext_if.slave bus
);

  localparam int unsigned NUM_LANES = calc_num_lanes(DATA_WIDTH);
  localparam int unsigned DEPTH     = calc_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_t            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;
  logic                  s0_valid_q;
  logic [DATA_WIDTH-1:0] s0_data_q;

  logic                  rd_accept;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  assign rd_accept = rst && (state_q == IDLE) && bus.read_en;
  assign wr_accept = rst && (state_q == IDLE) && bus.write;

  // Write-first returns the old word with this cycle's enabled lanes patched in.
  always_comb begin
    rd_data = mem[bus.read_addr];
    if ((RDW_MODE == RDW_WRITE_FIRST) && wr_accept && (bus.write_addr == bus.read_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.write_be[i]) rd_data[8*i +: 8] = bus.din[8*i +: 8];
      end
    end
  end

  // Storage has no reset; only the clear sequencer or accepted writes touch it.
  always_ff @(posedge clk) begin
    if (rst && (state_q == CLEAR)) begin
      mem[cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.write_be[i]) mem[bus.write_addr][8*i +: 8] <= bus.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q      <= '0;
      busy_q     <= CLEAR_ON_RESET;
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= rd_accept;
      if (rd_accept) s0_data_q <= rd_data;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (&cnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE:    busy_q <= 1'b0;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ram_rd_pipe #(
    .STAGES    (READ_LATENCY - 1),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .valid_i(s0_valid_q),
    .data_i (s0_data_q),
    .valid_o(pipe_valid),
    .data_o (pipe_data)
  );

  assign bus.dout       = pipe_data;
  assign bus.dout_valid = pipe_valid;
  assign bus.busy       = busy_q;

endmodule
